mode_sequencer: RTL

- Frame-synchronous scheduler that drives the 8-bit mode_params byte consumed by the video pattern controller.
- Holds a small table of {params, hold-count, last-flag} slots and steps through them.
- Changes params only at end-of-frame, using the vmax pulse from vga_sync, so pattern and timing-mode switches never tear mid-frame.
- Sits between the config/input logic and the pattern controller.

---
 rtl/mode_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - frame-synchronous scheduler stepping mode_params through a slot table
// Applies new params only on the vmax end-of-frame pulse so pattern/timing switches never tear.
module mode_sequencer #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vmax,
    input  logic              run,
    input  logic              step,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [7:0]        cfg_data,
    input  logic [7:0]        cfg_hold,
    input  logic              cfg_last,
    output logic              cfg_ready,
    output logic [7:0]        mode_params,
    output logic [ADDR_W-1:0] slot,
    output logic              changed,
    output logic              active
);

    localparam int SLOTS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        tbl_data [SLOTS];
    logic [7:0]        tbl_hold [SLOTS];
    logic              tbl_last [SLOTS];
    logic [7:0]        frame_cnt;
    logic              step_pending;
    logic [ADDR_W-1:0] next_slot;
    logic              advance;

    assign cfg_ready = (state == IDLE);

    always_comb begin
        next_slot = slot + 1'b1;
        if (tbl_last[slot] || slot == ADDR_W'(SLOTS - 1)) begin
            next_slot = '0;
        end
    end

    // A same-cycle step counts, so a step arriving with vmax advances on that frame edge.
    assign advance = (frame_cnt == 8'd0) || step_pending || step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mode_params  <= 8'h00;
            slot         <= '0;
            changed      <= 1'b0;
            active       <= 1'b0;
            frame_cnt    <= 8'd0;
            step_pending <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                tbl_data[i] <= 8'h00;
                tbl_hold[i] <= 8'h00;
                tbl_last[i] <= 1'b0;
            end
        end else begin
            changed <= 1'b0;

            if (cfg_we && state == IDLE) begin
                tbl_data[cfg_addr] <= cfg_data;
                tbl_hold[cfg_addr] <= cfg_hold;
                tbl_last[cfg_addr] <= cfg_last;
            end

            case (state)
                IDLE: begin
                    step_pending <= 1'b0;
                    active       <= 1'b0;
                    if (run) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    step_pending <= 1'b0;
                    if (!run) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else if (vmax) begin
                        state       <= RUN;
                        active      <= 1'b1;
                        mode_params <= tbl_data[0];
                        frame_cnt   <= tbl_hold[0];
                        slot        <= '0;
                        changed     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state        <= IDLE;
                        active       <= 1'b0;
                        step_pending <= 1'b0;
                    end else if (vmax) begin
                        if (advance) begin
                            mode_params  <= tbl_data[next_slot];
                            frame_cnt    <= tbl_hold[next_slot];
                            slot         <= next_slot;
                            changed      <= 1'b1;
                            step_pending <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt - 8'd1;
                        end
                    end else if (step) begin
                        step_pending <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
